// File: rtl/jstk_pkg.sv
// Shared types and constants for the PMOD JSTK poll scheduler.
package jstk_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CSLO,
      SHIFT,
      GAP,
      DONE
   } jstk_state_t;

   localparam int         JSTK_NBYTES  = 5;
   localparam logic [9:0] JSTK_CENTER  = 10'd512;
   localparam logic [5:0] JSTK_LED_CMD = 6'b100000;

   function automatic logic [7:0] jstk_cmd_byte(input logic [1:0] led);
      return {JSTK_LED_CMD, led};
   endfunction

endpackage

// File: rtl/spi_byte_xfer.sv
// One SPI mode-0 byte: SCLK low half first, MOSI updated on the falling edge,
// MISO sampled on the rising edge, MSB first; done pulses after the last fall.
module spi_byte_xfer #(
   parameter int SCLK_HALF = 33
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] tx,
   input  logic       miso,
   output logic [7:0] rx,
   output logic       done,
   output logic       sclk,
   output logic       mosi
);

   localparam int HW = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;

   logic          active_q, active_d;
   logic          sclk_q, sclk_d;
   logic          mosi_q, mosi_d;
   logic          done_q, done_d;
   logic [6:0]    sh_q, sh_d;
   logic [7:0]    rx_q, rx_d;
   logic [2:0]    bit_q, bit_d;
   logic [HW-1:0] half_q, half_d;

   always_comb begin
      active_d = active_q;
      sclk_d   = sclk_q;
      mosi_d   = mosi_q;
      done_d   = 1'b0;
      sh_d     = sh_q;
      rx_d     = rx_q;
      bit_d    = bit_q;
      half_d   = half_q;
      if (start) begin
         active_d = 1'b1;
         sclk_d   = 1'b0;
         mosi_d   = tx[7];
         sh_d     = tx[6:0];
         bit_d    = 3'd0;
         half_d   = '0;
      end else if (active_q) begin
         if (half_q == HW'(SCLK_HALF - 1)) begin
            half_d = '0;
            if (!sclk_q) begin
               sclk_d = 1'b1;
               rx_d   = {rx_q[6:0], miso};
            end else begin
               sclk_d = 1'b0;
               if (bit_q == 3'd7) begin
                  active_d = 1'b0;
                  done_d   = 1'b1;
                  mosi_d   = 1'b0;
               end else begin
                  bit_d  = bit_q + 3'd1;
                  mosi_d = sh_q[6];
                  sh_d   = {sh_q[5:0], 1'b0};
               end
            end
         end else begin
            half_d = half_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         active_q <= 1'b0;
         sclk_q   <= 1'b0;
         mosi_q   <= 1'b0;
         done_q   <= 1'b0;
         sh_q     <= '0;
         rx_q     <= '0;
         bit_q    <= '0;
         half_q   <= '0;
      end else begin
         active_q <= active_d;
         sclk_q   <= sclk_d;
         mosi_q   <= mosi_d;
         done_q   <= done_d;
         sh_q     <= sh_d;
         rx_q     <= rx_d;
         bit_q    <= bit_d;
         half_q   <= half_d;
      end
   end

   assign sclk = sclk_q;
   assign mosi = mosi_q;
   assign rx   = rx_q;
   assign done = done_q;

endmodule

// File: rtl/jstk_poll_sched.sv
// Periodic PMOD JSTK poller on a shared SPI bus. Define JSTK_DUAL_EN to serve
// two joysticks round-robin; otherwise only joystick 0 is polled.
module jstk_poll_sched
   import jstk_pkg::*;
#(
   parameter int SCLK_HALF   = 33,
   parameter int CS_SETUP    = 975,
   parameter int BYTE_GAP    = 650,
   parameter int POLL_PERIOD = 650000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       miso,
   output logic       sclk,
   output logic       mosi,
   output logic       cs0,
   output logic       cs1,
   input  logic [1:0] led0,
   input  logic [1:0] led1,
   output logic [9:0] x0,
   output logic [9:0] y0,
   output logic [2:0] btn0,
   output logic       valid0,
   output logic [9:0] x1,
   output logic [9:0] y1,
   output logic [2:0] btn1,
   output logic       valid1,
   output logic       busy
);

`ifdef JSTK_DUAL_EN
   localparam int NDEV = 2;
`else
   localparam int NDEV = 1;
`endif
   localparam int TW   = $clog2(POLL_PERIOD);
   localparam int CMAX = (CS_SETUP > BYTE_GAP) ? CS_SETUP : BYTE_GAP;
   localparam int CW   = $clog2(CMAX + 1);

   jstk_state_t   state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    idx_q, idx_d;
   logic          dev_q, dev_d;
   logic          pending_q, pending_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [1:0]    cs_q, cs_d;
   logic          busy_q, busy_d;
   logic [7:0]    rxb_q [JSTK_NBYTES];
   logic [7:0]    rxb_d [JSTK_NBYTES];

   logic          tick;
   logic          xfer_start;
   logic [7:0]    xfer_tx;
   logic [7:0]    xfer_rx;
   logic          xfer_done;
   logic [1:0]    led_sel;

`ifdef JSTK_DUAL_EN
   assign led_sel = dev_q ? led1 : led0;
`else
   assign led_sel = led0;
`endif

   assign tick = (timer_q == TW'(POLL_PERIOD - 1));

   // The SCLK low half of the first bit counts toward the CS setup time.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      idx_d      = idx_q;
      dev_d      = dev_q;
      cs_d       = cs_q;
      busy_d     = busy_q;
      rxb_d      = rxb_q;
      timer_d    = tick ? '0 : timer_q + 1'b1;
      pending_d  = pending_q | tick;
      xfer_start = 1'b0;
      xfer_tx    = 8'h00;
      case (state_q)
         IDLE: begin
            if (pending_q || tick) begin
               pending_d = 1'b0;
               cs_d      = dev_q ? 2'b01 : 2'b10;
               busy_d    = 1'b1;
               cnt_d     = '0;
               state_d   = CSLO;
            end
         end
         CSLO: begin
            if (cnt_q == CW'(CS_SETUP - SCLK_HALF - 1)) begin
               xfer_start = 1'b1;
               xfer_tx    = jstk_cmd_byte(led_sel);
               idx_d      = 3'd0;
               state_d    = SHIFT;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         SHIFT: begin
            if (xfer_done) begin
               rxb_d[idx_q] = xfer_rx;
               if (idx_q == 3'(JSTK_NBYTES - 1)) begin
                  cs_d    = 2'b11;
                  busy_d  = 1'b0;
                  state_d = DONE;
               end else begin
                  cnt_d   = '0;
                  state_d = GAP;
               end
            end
         end
         GAP: begin
            if (cnt_q == CW'(BYTE_GAP - 1)) begin
               xfer_start = 1'b1;
               idx_d      = idx_q + 3'd1;
               state_d    = SHIFT;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DONE: begin
`ifdef JSTK_DUAL_EN
            dev_d = ~dev_q;
`endif
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         idx_q     <= '0;
         dev_q     <= 1'b0;
         pending_q <= 1'b0;
         timer_q   <= '0;
         cs_q      <= 2'b11;
         busy_q    <= 1'b0;
         rxb_q     <= '{default: 8'h00};
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         dev_q     <= dev_d;
         pending_q <= pending_d;
         timer_q   <= timer_d;
         cs_q      <= cs_d;
         busy_q    <= busy_d;
         rxb_q     <= rxb_d;
      end
   end

   spi_byte_xfer #(
      .SCLK_HALF(SCLK_HALF)
   ) u_xfer (
      .clk  (clk),
      .rst  (rst),
      .start(xfer_start),
      .tx   (xfer_tx),
      .miso (miso),
      .rx   (xfer_rx),
      .done (xfer_done),
      .sclk (sclk),
      .mosi (mosi)
   );

   // Outputs copy the completed rx buffer in the cycle after CS release.
   for (genvar gi = 0; gi < NDEV; gi++) begin : g_dev
      logic [9:0] x_q, x_d, y_q, y_d;
      logic [2:0] btn_q, btn_d;
      logic       valid_q, valid_d;
      logic       hit;

      assign hit = (state_q == DONE) && (dev_q == 1'(gi));

      always_comb begin
         x_d     = x_q;
         y_d     = y_q;
         btn_d   = btn_q;
         valid_d = hit;
         if (hit) begin
            x_d   = {rxb_q[1][1:0], rxb_q[0]};
            y_d   = {rxb_q[3][1:0], rxb_q[2]};
            btn_d = rxb_q[4][2:0];
         end
      end

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            x_q     <= JSTK_CENTER;
            y_q     <= JSTK_CENTER;
            btn_q   <= 3'b000;
            valid_q <= 1'b0;
         end else begin
            x_q     <= x_d;
            y_q     <= y_d;
            btn_q   <= btn_d;
            valid_q <= valid_d;
         end
      end
   end

   assign cs0    = cs_q[0];
   assign busy   = busy_q;
   assign x0     = g_dev[0].x_q;
   assign y0     = g_dev[0].y_q;
   assign btn0   = g_dev[0].btn_q;
   assign valid0 = g_dev[0].valid_q;

`ifdef JSTK_DUAL_EN
   logic unused_rx_bits;
   assign unused_rx_bits = ^{rxb_q[1][7:2], rxb_q[3][7:2], rxb_q[4][7:3]};
   assign cs1    = cs_q[1];
   assign x1     = g_dev[1].x_q;
   assign y1     = g_dev[1].y_q;
   assign btn1   = g_dev[1].btn_q;
   assign valid1 = g_dev[1].valid_q;
`else
   logic unused_rx_bits;
   assign unused_rx_bits = ^{rxb_q[1][7:2], rxb_q[3][7:2], rxb_q[4][7:3], led1, cs_q[1]};
   assign cs1    = 1'b1;
   assign x1     = JSTK_CENTER;
   assign y1     = JSTK_CENTER;
   assign btn1   = 3'b000;
   assign valid1 = 1'b0;
`endif

   a_one_cs: assert property (@(posedge clk) disable iff (rst) (cs_q != 2'b00));

endmodule
